// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the instruction ROM.
// Sequences execution from start to halt, applying stalls, absolute and
// relative jumps, and reports a sticky sequential-overflow flag and a
// saturating RUN-cycle counter.
module fetch_sequencer #(
  parameter int D          = 12,
  parameter int OW         = 8,
  parameter int CW         = 16,
  parameter int START_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          halt_req,
  input  logic          stall,
  input  logic          jump_abs,
  input  logic          jump_rel,
  input  logic [D-1:0]  target,
  input  logic [OW-1:0] offset,
  output logic [D-1:0]  prog_ctr_out,
  output logic          fetch_valid,
  output logic          busy,
  output logic          done,
  output logic          pc_overflow,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [D-1:0] START_PC = D'(START_ADDR);

  state_t        state, state_n;
  logic [D-1:0]  pc, pc_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ovf, ovf_n;

  // Offset is sign-extended past D bits, then truncated so the add wraps
  // modulo 2**D whether OW is narrower or wider than D.
  logic [D+OW-1:0] off_ext;
  logic [D-1:0]    pc_rel;

  // Relative-branch target, computed modulo 2**D.
  always_comb begin
    off_ext = {{D{offset[OW-1]}}, offset};
    pc_rel  = pc + off_ext[D-1:0];
  end

  // State, PC, counter and overflow registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      pc    <= START_PC;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
  end

  // Next-state and next-PC selection; in RUN the first matching request wins.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = START_PC;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      S_RUN: begin
        if (cnt != '1) cnt_n = cnt + 1'b1;
        if (halt_req) begin
          state_n = S_DONE;
        end else if (stall) begin
          pc_n = pc;
        end else if (jump_abs) begin
          pc_n = target;
        end else if (jump_rel) begin
          pc_n = pc_rel;
        end else if (pc == '1) begin
          state_n = S_DONE;
          ovf_n   = 1'b1;
        end else begin
          pc_n = pc + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state; stall alone gates fetch_valid.
  always_comb begin
    prog_ctr_out = pc;
    cycle_count  = cnt;
    pc_overflow  = ovf;
    busy         = (state == S_RUN);
    done         = (state == S_DONE);
    fetch_valid  = (state == S_RUN) && !stall;
  end

endmodule
